pcie_host_rsp: RTL

PCIE_HOST_RSP -- requirements
Module: pcie_host_rsp

---
 rtl/pcie_host_rsp.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/pcie_host_rsp.sv
// Host-memory responder for PCIe-style read/write requests with fixed response latency.
// Optional statistics counters are enabled by defining PCIE_HOST_RSP_STATS_EN.
module pcie_host_rsp #(
  parameter int unsigned DEPTH     = 256,
  parameter logic [63:0] BASE_ADDR = 64'h0,
  parameter int unsigned LATENCY   = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         RdRqValid,
  input  logic [63:0]  RdRqAddr,
  output logic [127:0] RdRqData,
  output logic         RdRqReady,
  output logic         RdRqErr,
  input  logic         WrRqValid,
  input  logic [63:0]  WrRqAddr,
  input  logic [127:0] WrRqData,
  output logic         WrRqReady,
`ifdef PCIE_HOST_RSP_STATS_EN
  output logic         WrRqErr,
  output logic [31:0]  RdCnt,
  output logic [31:0]  WrCnt,
  output logic [15:0]  ErrCnt
`else
  output logic         WrRqErr
`endif
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam int unsigned CW       = 6;
  localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY - 1);
  localparam logic [63:0]   SPAN     = 64'(DEPTH) << 4;

  typedef enum logic [2:0] {IDLE, RD_WAIT, WR_WAIT, RD_RESP, WR_RESP, DROP} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [63:0]    addr_q, addr_d;
  logic [127:0]   wdata_q, wdata_d;
  logic           is_wr_q, is_wr_d;
  logic           rd_ready_q, rd_ready_d, wr_ready_q, wr_ready_d;
  logic           rd_err_q, rd_err_d, wr_err_q, wr_err_d;
  logic [127:0]   rd_data_q, rd_data_d;

  logic [127:0]   mem [DEPTH];
  logic           mem_we_c;
  logic [64:0]    diff_c;
  logic           addr_err_c;
  logic [AW-1:0]  idx_c;

  // Address decode; the 65th bit of the subtraction flags addr below BASE_ADDR.
  always_comb begin
    diff_c     = {1'b0, addr_q} - {1'b0, BASE_ADDR};
    addr_err_c = (addr_q[3:0] != 4'h0) || diff_c[64] || (diff_c[63:0] >= SPAN);
    idx_c      = AW'(diff_c[63:4]);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    is_wr_d    = is_wr_q;
    rd_ready_d = 1'b0;
    wr_ready_d = 1'b0;
    rd_err_d   = 1'b0;
    wr_err_d   = 1'b0;
    rd_data_d  = '0;
    mem_we_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (WrRqValid) begin
          addr_d  = WrRqAddr;
          wdata_d = WrRqData;
          is_wr_d = 1'b1;
          cnt_d   = '0;
          state_d = WR_WAIT;
        end else if (RdRqValid) begin
          addr_d  = RdRqAddr;
          is_wr_d = 1'b0;
          cnt_d   = '0;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d      = '0;
          state_d    = RD_RESP;
          rd_ready_d = 1'b1;
          rd_err_d   = addr_err_c;
          rd_data_d  = addr_err_c ? '0 : mem[idx_c];
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WR_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d      = '0;
          state_d    = WR_RESP;
          wr_ready_d = 1'b1;
          wr_err_d   = addr_err_c;
          mem_we_c   = !addr_err_c;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RD_RESP, WR_RESP: state_d = DROP;
      // Wait for the served initiator to release Valid so a held request is not re-accepted.
      DROP: begin
        if (is_wr_q ? !WrRqValid : !RdRqValid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      is_wr_q    <= 1'b0;
      rd_ready_q <= 1'b0;
      wr_ready_q <= 1'b0;
      rd_err_q   <= 1'b0;
      wr_err_q   <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      is_wr_q    <= is_wr_d;
      rd_ready_q <= rd_ready_d;
      wr_ready_q <= wr_ready_d;
      rd_err_q   <= rd_err_d;
      wr_err_q   <= wr_err_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Storage is deliberately outside the reset domain so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (mem_we_c) mem[idx_c] <= wdata_q;
  end

  assign RdRqData  = rd_data_q;
  assign RdRqReady = rd_ready_q;
  assign RdRqErr   = rd_err_q;
  assign WrRqReady = wr_ready_q;
  assign WrRqErr   = wr_err_q;

`ifdef PCIE_HOST_RSP_STATS_EN
  logic [31:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  // Saturating counters advance on the same edge that raises the Ready pulse.
  always_comb begin
    rd_cnt_d  = rd_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    err_cnt_d = err_cnt_q;
    if (rd_ready_d && (rd_cnt_q != '1)) rd_cnt_d = rd_cnt_q + 32'd1;
    if (wr_ready_d && (wr_cnt_q != '1)) wr_cnt_d = wr_cnt_q + 32'd1;
    if (((rd_ready_d && rd_err_d) || (wr_ready_d && wr_err_d)) && (err_cnt_q != '1))
      err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign RdCnt  = rd_cnt_q;
  assign WrCnt  = wr_cnt_q;
  assign ErrCnt = err_cnt_q;
`endif

endmodule
